// File: rtl/prog_clk_div_if.sv
// Divisor-load handshake between a configuration master and the clock divider.
interface prog_clk_div_if #(
  parameter int W = 8
);
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock-enable divider. A single counter produces a
// square wave of period cur_div; divisor and enable changes only land on a
// period boundary so the output never glitches.
module prog_clk_div #(
  parameter int W       = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  prog_clk_div_if.slave cfg,
  output logic          clk_out,
  output logic          tick,
  output logic [W-1:0]  cur_div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
  localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] cur_div_nxt;
  logic [W-1:0] pend_div, pend_div_nxt;
  logic         pend_vld, pend_vld_nxt;
  logic         err_r, err_nxt;
  logic         clk_out_nxt, tick_nxt;
  logic         running, running_nxt;
  logic         boundary;
  logic         cfg_hit;
  logic         accept;

  // Length of the high phase: the longer half for odd divisors, 1 for D=1.
  function automatic logic [W-1:0] high_len(input logic [W-1:0] d);
    return d - (d >> 1);
  endfunction

  // A divisor can be taken whenever no earlier one is still waiting.
  assign cfg.cfg_ready = ~pend_vld;
  assign cfg.cfg_err   = err_r;

  // Next-state, counter, divisor bookkeeping and registered-output values.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_div_nxt  = cur_div;
    pend_vld_nxt = pend_vld;
    pend_div_nxt = pend_div;

    running  = (state != IDLE);
    boundary = running && (cnt == cur_div - ONE);
    cfg_hit  = cfg.cfg_valid && !pend_vld;
    accept   = cfg_hit && (cfg.cfg_div != '0);
    err_nxt  = cfg_hit && (cfg.cfg_div == '0);

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // A divisor captured on the boundary that stopped us lands here.
        if (pend_vld) begin
          cur_div_nxt  = pend_div;
          pend_vld_nxt = 1'b0;
        end else if (accept) begin
          cur_div_nxt = cfg.cfg_div;
        end
        if (en) state_nxt = RUN;
      end
      RUN, STOP: begin
        cnt_nxt = boundary ? '0 : cnt + ONE;
        if (boundary && pend_vld) begin
          cur_div_nxt  = pend_div;
          pend_vld_nxt = 1'b0;
        end
        // Ready is low while pending, so this never collides with the swap.
        if (accept) begin
          pend_vld_nxt = 1'b1;
          pend_div_nxt = cfg.cfg_div;
        end
        if (en)            state_nxt = RUN;
        else if (boundary) state_nxt = IDLE;
        else               state_nxt = STOP;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    running_nxt = (state_nxt != IDLE);
    clk_out_nxt = running_nxt && (cnt_nxt < high_len(cur_div_nxt));
    tick_nxt    = running_nxt && (cnt_nxt == '0);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DEF_DIV_W;
      pend_vld <= 1'b0;
      err_r    <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= cur_div_nxt;
      pend_vld <= pend_vld_nxt;
      err_r    <= err_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
    end
  end

  // Pending divisor value; only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    pend_div <= pend_div_nxt;
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: table of per-cycle vectors plus hand-built
// sequences, expected outputs queued at drive time and checked after the edge.
module tb_prog_clk_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clk_out;
  logic       tick;
  logic [7:0] cur_div;

  prog_clk_div_if #(.W(8)) cfg ();

  prog_clk_div #(.W(8), .DEF_DIV(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg.slave),
    .clk_out (clk_out),
    .tick    (tick),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       c;
    logic       t;
    logic       r;
    logic       e;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       cv;
    logic [7:0] cd;
    exp_t       x;
  } vec_t;

  exp_t  sb[$];
  string nm_q[$];
  vec_t  tbl[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic vec_t mkv(input logic r, input logic e, input logic cv,
                               input logic [7:0] cd, input logic xc, input logic xt,
                               input logic xr, input logic xe, input logic [7:0] xd);
    vec_t v;
    v.rst = r; v.en = e; v.cv = cv; v.cd = cd;
    v.x   = '{c: xc, t: xt, r: xr, e: xe, d: xd};
    return v;
  endfunction

  task automatic check();
    exp_t  x;
    string nm;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue, want an entry");
      return;
    end
    x  = sb.pop_front();
    nm = nm_q.pop_front();
    if ({clk_out, tick, cfg.cfg_ready, cfg.cfg_err, cur_div} !== x) begin
      n_fail++;
      $display("FAIL %s: got clk=%b tick=%b rdy=%b err=%b div=%0d, want clk=%b tick=%b rdy=%b err=%b div=%0d",
               nm, clk_out, tick, cfg.cfg_ready, cfg.cfg_err, cur_div,
               x.c, x.t, x.r, x.e, x.d);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic e, input logic cv,
                      input logic [7:0] cd, input logic xc, input logic xt,
                      input logic xr, input logic xe, input logic [7:0] xd);
    exp_t x;
    @(negedge clk);
    rst           = r;
    en            = e;
    cfg.cfg_valid = cv;
    cfg.cfg_div   = cd;
    x = '{c: xc, t: xt, r: xr, e: xe, d: xd};
    sb.push_back(x);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] k;
    logic [7:0] c;
    rst = 1'b1; en = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = '0;

    //            rst en cv cd      clk tick rdy err div
    tbl.push_back(mkv(1, 0, 0, 8'd0,  0, 0, 1, 0, 8'd2)); // reset
    tbl.push_back(mkv(0, 0, 0, 8'd0,  0, 0, 1, 0, 8'd2)); // idle
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 1, 1, 0, 8'd2)); // first high, latency 1
    tbl.push_back(mkv(0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 1, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 1, 8'd0,  1, 1, 1, 1, 8'd2)); // D=0 rejected
    tbl.push_back(mkv(0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd2)); // single err pulse
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 1, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 1, 8'd5,  0, 0, 0, 0, 8'd2)); // load 5, pending
    tbl.push_back(mkv(0, 1, 0, 8'd9,  1, 1, 1, 0, 8'd5)); // boundary applies 5
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 0, 1, 0, 8'd5));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 0, 1, 0, 8'd5));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd5));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd5));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 1, 1, 0, 8'd5));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 0, 1, 0, 8'd5));
    tbl.push_back(mkv(0, 1, 1, 8'd7,  1, 0, 0, 0, 8'd5)); // pend 7
    tbl.push_back(mkv(1, 1, 0, 8'd0,  0, 0, 1, 0, 8'd2)); // reset mid-period
    tbl.push_back(mkv(0, 0, 0, 8'd0,  0, 0, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 1, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  0, 0, 1, 0, 8'd2));
    tbl.push_back(mkv(0, 1, 0, 8'd0,  1, 1, 1, 0, 8'd2)); // pending 7 dropped
    tbl.push_back(mkv(0, 0, 0, 8'd0,  0, 0, 1, 0, 8'd2)); // stop, finish period
    tbl.push_back(mkv(0, 0, 0, 8'd0,  0, 0, 1, 0, 8'd2)); // boundary -> idle
    tbl.push_back(mkv(0, 0, 1, 8'd3,  0, 0, 1, 0, 8'd3)); // idle load
    tbl.push_back(mkv(0, 0, 1, 8'd0,  0, 0, 1, 1, 8'd3)); // idle D=0
    tbl.push_back(mkv(0, 0, 0, 8'd0,  0, 0, 1, 0, 8'd3));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl%0d", i), tbl[i].rst, tbl[i].en, tbl[i].cv, tbl[i].cd,
           tbl[i].x.c, tbl[i].x.t, tbl[i].x.r, tbl[i].x.e, tbl[i].x.d);

    // D=1 then D=255
    step("d1_rst",   1, 0, 0, 8'd0,   0, 0, 1, 0, 8'd2);
    step("d1_load",  0, 0, 1, 8'd1,   0, 0, 1, 0, 8'd1);
    step("d1_start", 0, 1, 0, 8'd0,   1, 1, 1, 0, 8'd1);
    for (int i = 0; i < 5; i++)
      step($sformatf("d1_run%0d", i), 0, 1, 0, 8'd0, 1, 1, 1, 0, 8'd1);
    step("d255_acc", 0, 1, 1, 8'd255, 1, 1, 0, 0, 8'd1);
    step("d255_sw",  0, 1, 0, 8'd0,   1, 1, 1, 0, 8'd255);
    for (int i = 1; i <= 255; i++) begin
      c = (i == 255) ? 8'd0 : 8'(i);
      step($sformatf("d255_c%0d", i), 0, 1, 0, 8'd0,
           (c < 8'd128), (c == 8'd0), 1, 0, 8'd255);
    end

    // D=6 stop at cnt=2, then re-assert during cnt=4
    step("d6_rst",   1, 0, 0, 8'd0, 0, 0, 1, 0, 8'd2);
    step("d6_load",  0, 0, 1, 8'd6, 0, 0, 1, 0, 8'd6);
    step("d6_c0",    0, 1, 0, 8'd0, 1, 1, 1, 0, 8'd6);
    step("d6_c1",    0, 1, 0, 8'd0, 1, 0, 1, 0, 8'd6);
    step("d6_c2",    0, 1, 0, 8'd0, 1, 0, 1, 0, 8'd6);
    step("d6_s3",    0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_s4",    0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_s5",    0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_idle0", 0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_idle1", 0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_r0",    0, 1, 0, 8'd0, 1, 1, 1, 0, 8'd6);
    step("d6_r1",    0, 1, 0, 8'd0, 1, 0, 1, 0, 8'd6);
    step("d6_r2",    0, 1, 0, 8'd0, 1, 0, 1, 0, 8'd6);
    step("d6_r3",    0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_r4",    0, 0, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_r5",    0, 1, 0, 8'd0, 0, 0, 1, 0, 8'd6);
    step("d6_nogap", 0, 1, 0, 8'd0, 1, 1, 1, 0, 8'd6);
    step("d6_n1",    0, 1, 0, 8'd0, 1, 0, 1, 0, 8'd6);

    k = 8'(sb.size());
    n_cmp++;
    if (k != 8'd0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, want 0", k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
